move_input_controller: RTL and testbench
========================================

// Module: move_input_controller
// PURPOSE
//  Upstream front end of tic_tac_toe_game: turns a raw confirm button plus a
//  4-bit position switch bank into one-cycle playX/playO requests with
//  playerX_position/playerO_position. It owns turn order (X first) and enforces
//  a per-turn time limit; on expiry it auto-plays the lowest free cell.
//  It reads the current board back (pos1..pos9) to reject occupied cells.
// PARAMETERS
//  CLK_HZ          50_000_000  clock cycles per one-second tick
//  DEBOUNCE_CYCLES 1_000_000   cycles btn level must be stable to be accepted
//  TURN_SECONDS    10          seconds allowed per turn (1..15)
// PORTS
//  clk              in   1   system clock
//  rst              in   1   synchronous, active-high reset
//  btn_confirm      in   1   raw async push button, active-high
//  sw_position      in   4   requested cell: 0..8 = pos1..pos9; 9..15 invalid
//  board            in   18  {pos9,...,pos1}, 2 bits/cell, 2'b00 = empty
//  game_over        in   1   win or no_space from the game; ends play
//  playX            out  1   one-cycle move request for X
//  playO            out  1   one-cycle move request for O
//  playerX_position out  4   cell for X; 4'd15 when not issuing
//  playerO_position out  4   cell for O; 4'd15 when not issuing
//  turn             out  1   0 = X to move, 1 = O to move
//  time_left        out  4   whole seconds left in current turn
//  reject           out  1   one-cycle pulse: confirm with invalid/occupied cell
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state X_TURN, playX=playO=0, positions=4'd15,
//   turn=0, time_left=TURN_SECONDS, reject=0, debouncer/tick counters cleared.
//  Input path: 2-flop sync on btn_confirm; debounced level updates only after
//   DEBOUNCE_CYCLES consecutive equal samples; rising edge of debounced level
//   -> confirm (1 cycle). Press-to-confirm latency = 2 + DEBOUNCE_CYCLES cycles.
//  Tick: counter 0..CLK_HZ-1, tick=1 on wrap; counter cleared on turn change.
//  FSM states: X_TURN, X_ISSUE, O_TURN, O_ISSUE, DONE.
//   X_TURN/O_TURN: confirm & sw_position<=8 & board cell==00 -> latch cell,
//    go *_ISSUE. confirm otherwise -> reject=1 next cycle, stay.
//    tick with time_left==1 -> time_left=0, latch lowest-index empty cell,
//    go *_ISSUE; if no empty cell, reload time_left, stay.
//    tick otherwise -> time_left-1.
//   X_ISSUE: playX=1, playerX_position=latched cell for exactly 1 cycle;
//    next O_TURN, turn=1, time_left=TURN_SECONDS. O_ISSUE mirrors -> X_TURN.
//   DONE: all requests 0, positions 4'd15, time_left frozen; left only by rst.
//  Priority in one cycle: game_over > legal confirm > timeout > reject.
//   game_over in any state (incl. *_ISSUE) -> DONE next cycle, no request.
//  Confirm in *_ISSUE cycle is dropped (no queueing). Outputs registered.
//  Never playX and playO in same cycle; never two requests in a row.
// TESTING (bench uses CLK_HZ=20, DEBOUNCE_CYCLES=4, TURN_SECONDS=3)
//  Reset, sw=4, clean press -> exactly one playX pulse, playerX_position=4
//   at cycle 2+4+1 after press; turn=1, time_left=3.
//  Board cell 4 = 2'b01, O turn, sw=4 press -> reject pulse, no playO,
//   turn stays 1; sw=9 press -> reject pulse.
//  Bouncy press (toggle every 2 cycles for 20 cycles, then hold) -> one pulse.
//  Idle X turn, cells 0..2 occupied -> after 3 ticks (60 cycles) playX with
//   position 3, time_left reloads to 3, turn=1.
//  game_over raised same cycle as legal confirm -> no request, DONE; later
//   presses ignored until rst; rst mid-turn -> all outputs to reset values.

Source files
------------

// File: rtl/move_input_controller.sv
// Move input front end for the tic-tac-toe game: debounces the confirm button,
// tracks whose turn it is, enforces the per-turn time limit and issues one-cycle
// play requests for X or O.
module move_input_controller #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TURN_SECONDS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_confirm,
  input  logic [3:0]  sw_position,
  input  logic [17:0] board,
  input  logic        game_over,
  output logic        playX,
  output logic        playO,
  output logic [3:0]  playerX_position,
  output logic [3:0]  playerO_position,
  output logic        turn,
  output logic [3:0]  time_left,
  output logic        reject
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TICK_W = $clog2(CLK_HZ + 1);
  localparam logic [3:0]  NO_POS = 4'd15;
  localparam logic [3:0]  T_LOAD = 4'(TURN_SECONDS);

  typedef enum logic [2:0] {X_TURN, X_ISSUE, O_TURN, O_ISSUE, DONE} state_t;

  state_t            state, state_n;
  logic              sync1, sync2, db_level, db_prev, confirm;
  logic [DB_W-1:0]   db_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick, in_turn;
  logic [15:0]       free;
  logic [3:0]        lowest, cell_q, cell_n, time_n;
  logic              any_free, legal, turn_n, reject_n;

  // Two-flop synchroniser and counter-based debouncer on the raw button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_confirm;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign confirm = db_level & ~db_prev;
  assign in_turn = (state == X_TURN) || (state == O_TURN);
  assign tick    = in_turn && (tick_cnt == TICK_W'(CLK_HZ - 1));

  // One-second tick counter; held at zero outside the waiting states so every turn starts fresh.
  always_ff @(posedge clk) begin
    if (rst || !in_turn || tick) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Free-cell map and lowest free cell for the timeout auto-play.
  always_comb begin
    free     = '0;
    lowest   = NO_POS;
    any_free = 1'b0;
    for (int i = 0; i < 9; i++) free[i] = (board[2*i +: 2] == 2'b00);
    for (int i = 8; i >= 0; i--) begin
      if (free[i]) begin
        lowest   = 4'(i);
        any_free = 1'b1;
      end
    end
  end

  assign legal = confirm && (sw_position <= 4'd8) && free[sw_position];

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= X_TURN;
      cell_q           <= NO_POS;
      playX            <= 1'b0;
      playO            <= 1'b0;
      playerX_position <= NO_POS;
      playerO_position <= NO_POS;
      turn             <= 1'b0;
      time_left        <= T_LOAD;
      reject           <= 1'b0;
    end else begin
      state            <= state_n;
      cell_q           <= cell_n;
      playX            <= (state_n == X_ISSUE);
      playO            <= (state_n == O_ISSUE);
      playerX_position <= (state_n == X_ISSUE) ? cell_n : NO_POS;
      playerO_position <= (state_n == O_ISSUE) ? cell_n : NO_POS;
      turn             <= turn_n;
      time_left        <= time_n;
      reject           <= reject_n;
    end
  end

  // Next-state logic: game_over > legal confirm > timeout > reject.
  always_comb begin
    state_n  = state;
    cell_n   = cell_q;
    time_n   = time_left;
    turn_n   = turn;
    reject_n = 1'b0;
    if (game_over) begin
      state_n = DONE;
    end else begin
      case (state)
        X_TURN, O_TURN: begin
          if (legal) begin
            cell_n  = sw_position;
            state_n = (state == X_TURN) ? X_ISSUE : O_ISSUE;
          end else if (tick && (time_left == 4'd1)) begin
            if (any_free) begin
              time_n  = 4'd0;
              cell_n  = lowest;
              state_n = (state == X_TURN) ? X_ISSUE : O_ISSUE;
            end else begin
              time_n = T_LOAD;
            end
          end else begin
            if (tick)    time_n   = time_left - 4'd1;
            if (confirm) reject_n = 1'b1;
          end
        end
        X_ISSUE: begin
          state_n = O_TURN;
          turn_n  = 1'b1;
          time_n  = T_LOAD;
        end
        O_ISSUE: begin
          state_n = X_TURN;
          turn_n  = 1'b0;
          time_n  = T_LOAD;
        end
        default: state_n = DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_input_controller.sv
// Directed bench for move_input_controller with short tick/debounce constants.
module tb_move_input_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_confirm;
  logic [3:0]  sw_position;
  logic [17:0] board;
  logic        game_over;
  logic        playX, playO, turn, reject;
  logic [3:0]  playerX_position, playerO_position, time_left;

  int n_vec = 0;
  int n_err = 0;
  int pulses_x, pulses_o;
  logic [3:0] seen_pos;

  move_input_controller #(
    .CLK_HZ(20), .DEBOUNCE_CYCLES(4), .TURN_SECONDS(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_confirm(btn_confirm), .sw_position(sw_position),
    .board(board), .game_over(game_over), .playX(playX), .playO(playO),
    .playerX_position(playerX_position), .playerO_position(playerO_position),
    .turn(turn), .time_left(time_left), .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_playX"}, 32'(playX), 32'd0);
    chk({tag, "_playO"}, 32'(playO), 32'd0);
    chk({tag, "_posX"}, 32'(playerX_position), 32'd15);
    chk({tag, "_posO"}, 32'(playerO_position), 32'd15);
    chk({tag, "_turn"}, 32'(turn), 32'd0);
    chk({tag, "_time"}, 32'(time_left), 32'd3);
    chk({tag, "_reject"}, 32'(reject), 32'd0);
  endtask

  initial begin
    rst = 1'b1; btn_confirm = 1'b0; sw_position = 4'd0; board = '0; game_over = 1'b0;
    step(2);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Clean press, X plays cell 4 seven cycles later.
    sw_position = 4'd4; btn_confirm = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      chk("pressX_playX", 32'(playX), 32'(i == 7));
      chk("pressX_playO", 32'(playO), 32'd0);
    end
    chk("pressX_pos", 32'(playerX_position), 32'd4);
    step(1);
    chk("pressX_drop", 32'(playX), 32'd0);
    chk("pressX_posidle", 32'(playerX_position), 32'd15);
    chk("pressX_turn", 32'(turn), 32'd1);
    chk("pressX_time", 32'(time_left), 32'd3);
    board[9:8] = 2'b01;
    btn_confirm = 1'b0;

    // O presses occupied cell 4: reject, no play.
    step(8);
    btn_confirm = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      chk("occ_reject", 32'(reject), 32'(i == 7));
      chk("occ_playO", 32'(playO), 32'd0);
    end
    step(1);
    chk("occ_reject_drop", 32'(reject), 32'd0);
    chk("occ_turn", 32'(turn), 32'd1);
    btn_confirm = 1'b0;

    // O presses invalid position 9: reject.
    step(8);
    sw_position = 4'd9; btn_confirm = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      chk("inv_reject", 32'(reject), 32'(i == 7));
      chk("inv_playO", 32'(playO), 32'd0);
    end
    chk("inv_turn", 32'(turn), 32'd1);
    chk("inv_time", 32'(time_left), 32'd2);
    btn_confirm = 1'b0;

    // Reset in the middle of O's turn.
    rst = 1'b1;
    step(1);
    chk_reset_vals("midrst");
    step(1);
    rst = 1'b0;

    // Bouncy press for X on cell 7 yields a single request.
    sw_position = 4'd7;
    pulses_x = 0; pulses_o = 0; seen_pos = 4'd0;
    for (int i = 0; i < 50; i++) begin
      btn_confirm = (i >= 20) ? 1'b1 : (((i / 2) % 2) == 0);
      step(1);
      if (playX) begin pulses_x++; seen_pos = playerX_position; end
      if (playO) pulses_o++;
    end
    chk("bounce_xcount", 32'(pulses_x), 32'd1);
    chk("bounce_ocount", 32'(pulses_o), 32'd0);
    chk("bounce_pos", 32'(seen_pos), 32'd7);
    chk("bounce_turn", 32'(turn), 32'd1);
    btn_confirm = 1'b0;

    // Idle X turn with cells 0..2 taken: timeout auto-plays cell 3.
    rst = 1'b1;
    board = {12'b0, 6'b10_01_01};
    step(2);
    rst = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      step(1);
      if (i <= 60) chk("tmo_playX", 32'(playX), 32'(i == 60));
      if (i == 20) chk("tmo_time20", 32'(time_left), 32'd2);
      if (i == 59) chk("tmo_time59", 32'(time_left), 32'd1);
      if (i == 60) begin
        chk("tmo_pos", 32'(playerX_position), 32'd3);
        chk("tmo_time0", 32'(time_left), 32'd0);
      end
    end
    chk("tmo_drop", 32'(playX), 32'd0);
    chk("tmo_turn", 32'(turn), 32'd1);
    chk("tmo_reload", 32'(time_left), 32'd3);

    // game_over together with a legal confirm: no request, then locked out.
    rst = 1'b1;
    board = '0;
    step(2);
    rst = 1'b0;
    sw_position = 4'd2; btn_confirm = 1'b1;
    step(6);
    game_over = 1'b1;
    step(1);
    chk("go_playX", 32'(playX), 32'd0);
    chk("go_posX", 32'(playerX_position), 32'd15);
    game_over = 1'b0; btn_confirm = 1'b0;
    step(1);
    chk("go_playX2", 32'(playX), 32'd0);
    chk("go_turn", 32'(turn), 32'd0);
    step(8);
    sw_position = 4'd5; btn_confirm = 1'b1;
    pulses_x = 0; pulses_o = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (playX || playO || reject) pulses_x++;
    end
    chk("done_requests", 32'(pulses_x), 32'd0);
    chk("done_time_frozen", 32'(time_left), 32'd3);
    chk("done_turn", 32'(turn), 32'd0);
    btn_confirm = 1'b0;

    // Reset leaves DONE and clears outputs.
    rst = 1'b1;
    step(1);
    chk_reset_vals("donerst");
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
